// File: rtl/alu_pkg.sv
// Opcode encodings and sequencer state type shared by the serial ALU and its issuer.
package alu_pkg;

    localparam logic [2:0] OPC_RV0  = 3'b000;
    localparam logic [2:0] OPC_OR   = 3'b001;
    localparam logic [2:0] OPC_ADD  = 3'b010;
    localparam logic [2:0] OPC_SUB  = 3'b011;
    localparam logic [2:0] OPC_RV1  = 3'b100;
    localparam logic [2:0] OPC_XNOR = 3'b101;
    localparam logic [2:0] OPC_AND  = 3'b110;
    localparam logic [2:0] OPC_XOR  = 3'b111;

    typedef enum logic [2:0] {
        OP_RV0  = OPC_RV0,
        OP_OR   = OPC_OR,
        OP_ADD  = OPC_ADD,
        OP_SUB  = OPC_SUB,
        OP_RV1  = OPC_RV1,
        OP_XNOR = OPC_XNOR,
        OP_AND  = OPC_AND,
        OP_XOR  = OPC_XOR
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: combines the current operand bits with the running
// carry/flag bit c and produces the result bit and the next flag value.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    c,
    input  alu_op_t op,
    output logic    out,
    output logic    cout
);

    // Per-opcode result bit and flag update; the flag opcodes with op[2]=1
    // start at 1 and accumulate with AND, the rest start at 0.
    always_comb begin
        out  = 1'b0;
        cout = c;
        case (op)
            OP_RV0: begin
                out  = a;
                cout = c;
            end
            OP_OR: begin
                out  = a | b;
                cout = c | a | b;
            end
            OP_ADD: begin
                out  = a ^ b ^ c;
                cout = (a & b) | (a & c) | (b & c);
            end
            OP_SUB: begin
                out  = a ^ b ^ c;
                cout = (~a & b) | (~a & c) | (b & c);
            end
            OP_RV1: begin
                out  = a & ~b;
                cout = c & a & ~b;
            end
            OP_XNOR: begin
                out  = ~(a ^ b);
                cout = c & ~(a ^ b);
            end
            OP_AND: begin
                out  = a & b;
                cout = c & a & b;
            end
            OP_XOR: begin
                out  = a ^ b;
                cout = c & (a ^ b);
            end
            default: begin
                out  = 1'b0;
                cout = c;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: accepts one WIDTH-bit operation, runs it LSB
// first through a single alu_bit_slice, and presents result plus flag.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | in_ready=1, waiting for a request
//   S_SHIFT | one bit per cycle through the slice, cnt counts 0..WIDTH-1
//   S_DONE  | out_valid=1, result and flag held until out_ready
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_flag
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    alu_op_t          op_q;
    logic             flag_q;
    logic [CW-1:0]    cnt_q;
    logic             bit_out;
    logic             bit_cout;

    alu_bit_slice u_slice (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .c    (flag_q),
        .op   (op_q),
        .out  (bit_out),
        .cout (bit_cout)
    );

    // Handshake outputs depend on state only, never on the partner's valid/ready.
    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = res_q;
    assign out_flag   = flag_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)          state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  if (out_ready)         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // Operand/result shift registers, flag register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            op_q   <= OP_RV0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q    <= in_a;
                        b_q    <= in_b;
                        op_q   <= alu_op_t'(in_op);
                        flag_q <= in_op[2];
                        cnt_q  <= '0;
                    end
                end
                S_SHIFT: begin
                    a_q    <= {1'b0, a_q[WIDTH-1:1]};
                    b_q    <= {1'b0, b_q[WIDTH-1:1]};
                    res_q  <= {bit_out, res_q[WIDTH-1:1]};
                    flag_q <= bit_cout;
                    // Explicit wrap keeps non-power-of-two widths clean.
                    cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
